// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared types and load formatting for the data-memory responder
package data_memory_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_type;

    typedef enum logic {
        DMEM_IDLE,
        DMEM_LOAD
    } dmem_state_type;

    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  offset,
        input logic [2:0]  funct3
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            MEM_B:   load_extend = {{24{b[7]}}, b};
            MEM_H:   load_extend = {{16{h[15]}}, h};
            MEM_BU:  load_extend = {24'b0, b};
            MEM_HU:  load_extend = {16'b0, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM with per-byte write enables
module dmem_ram #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (|we) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end else if (re) begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/data_memory.sv
// data_memory: RV32I load/store responder; DMEM_MISALIGN_CHECK_EN turns misaligned H/W accesses into error responses
module data_memory
    import data_memory_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_type state, state_next;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        err_q;
    logic        accept, is_h, is_w, mis;
    logic [3:0]  be, ram_we;
    logic        ram_re;
    logic [31:0] ram_wdata, ram_rdata;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:AW+2];
    assign is_w = req_funct3[1];
    assign is_h = req_funct3[1:0] == 2'b01;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis = (is_h && req_addr[0]) || (is_w && req_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    assign be        = is_w ? 4'hF : is_h ? (req_addr[1] ? 4'hC : 4'h3) : 4'b0001 << req_addr[1:0];
    assign ram_wdata = is_w ? req_wdata : is_h ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
    assign ram_we    = (accept && req_write && !mis) ? be : 4'b0000;
    assign ram_re    = accept && !req_write && !mis;

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .re   (ram_re),
        .we   (ram_we),
        .addr (req_addr[2 +: AW]),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // occupancy FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DMEM_IDLE;
        else      state <= state_next;
    end

    // next state and handshake: loads and error cycles occupy one extra cycle
    always_comb begin
        req_ready  = state == DMEM_IDLE;
        resp_valid = state == DMEM_LOAD;
        accept     = req_ready && req_valid;
        state_next = (accept && (!req_write || mis)) ? DMEM_LOAD : DMEM_IDLE;
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q) ? load_extend(ram_rdata, off_q, f3_q) : 32'b0;
    end

    // capture offset, size and error status of the accepted request for the response cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            off_q <= 2'b00;
            f3_q  <= 3'b000;
            err_q <= 1'b0;
        end else if (accept) begin
            off_q <= req_addr[1:0];
            f3_q  <= req_funct3;
            err_q <= mis;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized load/store traffic against a byte-array reference model
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int errors = 0;
    int checks = 0;
    logic [7:0]  mb [256];
    logic [31:0] last_rdata;
    logic        last_err;

    data_memory dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_funct3(req_funct3),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] f);
        return f[1] ? 4 : f[0] ? 2 : 1;
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [2:0] f);
`ifdef DMEM_MISALIGN_CHECK_EN
        return (a % size_of(f)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
        int unsigned n  = size_of(f);
        logic [31:0] ea = a & ~(n - 1);
        logic [31:0] v  = 0;
        for (int k = 0; k < int'(n); k++) v |= 32'(mb[(ea + k) & 255]) << (8 * k);
        if (n < 4 && !f[2] && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        int unsigned n  = size_of(f);
        logic [31:0] ea = a & ~(n - 1);
        for (int k = 0; k < int'(n); k++) mb[(ea + k) & 255] = d[8*k +: 8];
    endtask

    // one request, entered and left at a falling edge; stores leave req_valid for the next call
    task automatic op(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        bit mis = misaligned(a, f);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_funct3 = f;
        check("ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        if (!wr || mis) begin
            last_rdata = resp_rdata;
            last_err   = resp_err;
            check("resp_valid", resp_valid, 1);
            check("ready_busy", req_ready, 0);
            check("resp_err", resp_err, mis);
            check("resp_rdata", resp_rdata, mis ? 32'h0 : model_load(a, f));
            @(negedge clk);
            check("resp_pulse", resp_valid, 0);
        end else begin
            check("store_noresp", resp_valid, 0);
            model_store(a, d, f);
        end
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  f;
        logic [2:0]  ops [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        rst = 1'b1;
        @(negedge clk);

        // back-to-back word stores fill the modelled region, upper address bits must wrap
        for (int w = 0; w < 64; w++) op(1'b1, (w * 4) | ($urandom & 32'hFFFF_F000), $urandom, 3'b010);

        op(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        op(1'b0, 32'h10, 0, 3'b010);  check("lw_10", last_rdata, 32'hDEADBEEF);
        op(1'b0, 32'h13, 0, 3'b000);  check("lb_13", last_rdata, 32'hFFFFFFDE);
        op(1'b0, 32'h13, 0, 3'b100);  check("lbu_13", last_rdata, 32'h000000DE);
        op(1'b0, 32'h12, 0, 3'b001);  check("lh_12", last_rdata, 32'hFFFFDEAD);
        op(1'b0, 32'h10, 0, 3'b101);  check("lhu_10", last_rdata, 32'h0000BEEF);
        op(1'b1, 32'h11, 32'h55, 3'b000);
        op(1'b0, 32'h10, 0, 3'b010);  check("sb_lw", last_rdata, 32'hDEAD55EF);
        op(1'b1, 32'h12, 32'h1234, 3'b001);
        op(1'b0, 32'h10, 0, 3'b010);  check("sh_lw", last_rdata, 32'h123455EF);
        op(1'b0, 32'h12, 0, 3'b010);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_err", last_err, 1);
        check("mis_rdata", last_rdata, 32'h0);
`else
        check("mis_wrap", last_rdata, 32'h123455EF);
`endif
        op(1'b1, 32'h16, 32'hCAFEF00D, 3'b010);
        op(1'b0, 32'h10, 0, 3'b010);  check("mem_kept", last_rdata, 32'h123455EF);

        // a request presented during the busy cycle is not accepted or queued
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_funct3 = 3'b010;
        @(negedge clk);
        check("busy_ready", req_ready, 0);
        req_write = 1'b1; req_wdata = ~model_load(32'h20, 3'b010);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_drop", resp_valid, 0);
        op(1'b0, 32'h20, 0, 3'b010);

        for (int i = 0; i < 400; i++) begin
            a = $urandom_range(0, 255) | ($urandom & 32'hFFFF_F000);
            d = $urandom;
            f = ops[$urandom_range(0, 7)];
            op($urandom_range(0, 1) == 1, a, d, f);
        end

        // reset during the response cycle suppresses the pulse and keeps memory
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("arst_valid", resp_valid, 0);
        check("arst_ready", req_ready, 1);
        check("arst_rdata", resp_rdata, 0);
        check("arst_err", resp_err, 0);
        @(negedge clk);
        rst = 1'b1;
        op(1'b0, 32'h10, 0, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
